// File: rtl/paillier_pkg.sv
// -----------------------------------------------------------------------------
// paillier_pkg
// Shared definitions for the Paillier job sequencer:
//   - requester task codes (encrypt / decrypt / rng / illegal)
//   - modexp engine op codes
//   - sequencer FSM state encoding
//   - per-task last-step index (number of engine steps minus one)
// -----------------------------------------------------------------------------
package paillier_pkg;

  typedef enum logic [1:0] {
    TASK_ENC = 2'b00,
    TASK_DEC = 2'b01,
    TASK_RNG = 2'b10,
    TASK_ILL = 2'b11
  } task_e;

  typedef enum logic [1:0] {
    OP_MODEXP_N2 = 2'b00,
    OP_MODMUL_N2 = 2'b01,
    OP_MODEXP_N  = 2'b10,
    OP_MODMUL_N  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_ISSUE         = 3'd1,
    ST_WAIT          = 3'd2,
    ST_RESP          = 3'd3,
    ST_REFRESH_ISSUE = 3'd4,
    ST_REFRESH_WAIT  = 3'd5
  } state_e;

  // Index of the final engine step for each task (steps are counted from 0).
  localparam logic [1:0] ENC_LAST_STEP = 2'd1;
  localparam logic [1:0] DEC_LAST_STEP = 2'd2;
  localparam logic [1:0] RNG_LAST_STEP = 2'd0;

  function automatic logic [1:0] last_step(input task_e t);
    case (t)
      TASK_ENC: last_step = ENC_LAST_STEP;
      TASK_DEC: last_step = DEC_LAST_STEP;
      default:  last_step = RNG_LAST_STEP;
    endcase
  endfunction

  // Width of a channel index; never below one bit.
  function automatic int idx_w(input int n);
    idx_w = (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter over NUM_CH request lines. The priority pointer names
// the channel that is searched first; after an accepted grant it moves to the
// channel just past the winner.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (pointer -> channel 0)
//   i_req          per-channel request vector
//   i_accept       the current grant was taken this cycle
//   o_grant        one-hot grant (zero when nothing requests)
//   o_grant_idx    binary index of the granted channel
//   o_grant_any    some channel is granted
// -----------------------------------------------------------------------------
module rr_arbiter
  import paillier_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int IDX_W = idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] i_req,
  input  logic              i_accept,
  output logic [NUM_CH-1:0] o_grant,
  output logic [IDX_W-1:0]  o_grant_idx,
  output logic              o_grant_any
);

  logic [IDX_W-1:0] r_ptr;
  int               w_dist;
  int               w_best;

  // Winner is the requester with the smallest circular distance from r_ptr.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_any = 1'b0;
    w_best      = NUM_CH;
    w_dist      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_dist = i - int'(r_ptr);
      if (w_dist < 0) w_dist = w_dist + NUM_CH;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best      = w_dist;
        o_grant     = '0;
        o_grant[i]  = 1'b1;
        o_grant_idx = IDX_W'(i);
        o_grant_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_accept) begin
      if (int'(o_grant_idx) == NUM_CH - 1) r_ptr <= '0;
      else                                 r_ptr <= o_grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/paillier_sequencer.sv
// -----------------------------------------------------------------------------
// paillier_sequencer
// Accepts encrypt / decrypt / rng jobs from NUM_CH requesters (round-robin),
// breaks each job into modexp/modmul steps on an external engine, and returns
// one response per job.
//   encrypt: modexp(N_PLUS_1_MONT, m)        -> modmul(prev, random)
//   decrypt: modexp(c, LAMBDA) -> modmul(prev-1, N_INV_R_MONT)
//                              -> modmul mod N(prev, MU_MONT)
//   rng    : modexp(random, N), result becomes the new random value
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              per-channel request handshake
//   req_task/req_data                per-channel task code and operand
//   rsp_valid/rsp_ready              response handshake
//   rsp_ch/rsp_data/rsp_err          originating channel, result, error flag
//   exp_start/exp_task               one-cycle engine start and engine op
//   exp_base/exp_exponent            engine operands, held until exp_done
//   exp_done/exp_power               engine completion pulse and result
//   busy                             a job (or refresh) is in flight
//   err_spurious                     sticky: exp_done seen while not waiting
// Configuration macro:
//   PAILLIER_RNG_REFRESH_EN          when defined, every encrypt response is
//                                    followed by a silent rng step that
//                                    refreshes the random register.
// -----------------------------------------------------------------------------
module paillier_sequencer
  import paillier_pkg::*;
#(
  parameter int                NUM_CH        = 4,
  parameter int                DATA_W        = 528,
  parameter logic [DATA_W-1:0] N             = '0,
  parameter logic [DATA_W-1:0] N_PLUS_1_MONT = '0,
  parameter logic [DATA_W-1:0] LAMBDA        = '0,
  parameter logic [DATA_W-1:0] N_INV_R_MONT  = '0,
  parameter logic [DATA_W-1:0] MU_MONT       = '0,
  parameter logic [DATA_W-1:0] RANDOM_SEED   = '0,
  localparam int               CH_W          = idx_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [2*NUM_CH-1:0]      req_task,
  input  logic [DATA_W*NUM_CH-1:0] req_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [CH_W-1:0]          rsp_ch,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic                     exp_start,
  output logic [1:0]               exp_task,
  output logic [DATA_W-1:0]        exp_base,
  output logic [DATA_W-1:0]        exp_exponent,
  input  logic                     exp_done,
  input  logic [DATA_W-1:0]        exp_power,
  output logic                     busy,
  output logic                     err_spurious
);

  state_e              r_state;
  state_e              w_state_nxt;
  task_e               r_task;
  logic [1:0]          r_step;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_prev;
  logic [DATA_W-1:0]   r_random;
  logic                r_live;

  logic                r_exp_start;
  op_e                 r_exp_task;
  logic [DATA_W-1:0]   r_exp_base;
  logic [DATA_W-1:0]   r_exp_exponent;
  logic [CH_W-1:0]     r_rsp_ch;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_err;
  logic                r_err_spurious;

  logic [NUM_CH-1:0]   w_gnt_vec;
  logic [CH_W-1:0]     w_gnt_idx;
  logic                w_gnt_any;
  logic                w_accept;
  task_e               w_gnt_task;
  logic [DATA_W-1:0]   w_gnt_data;
  logic                w_issue;
  logic                w_last;
  op_e                 w_op;
  logic [DATA_W-1:0]   w_base;
  logic [DATA_W-1:0]   w_expo;

  rr_arbiter #(
    .NUM_CH      (NUM_CH)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (req_valid),
    .i_accept    (w_accept),
    .o_grant     (w_gnt_vec),
    .o_grant_idx (w_gnt_idx),
    .o_grant_any (w_gnt_any)
  );

  // r_live is low while reset is held, so req_ready cannot follow req_valid
  // through the IDLE reset state before the sequencer is actually running.
  assign w_accept  = (r_state == ST_IDLE) && r_live && w_gnt_any;
  assign req_ready = w_accept ? w_gnt_vec : '0;
  assign w_last    = (r_step == last_step(r_task));

  // Task and operand of the granted channel, muxed by the one-hot grant.
  always_comb begin
    w_gnt_task = TASK_ENC;
    w_gnt_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_gnt_vec[i]) begin
        w_gnt_task = task_e'(req_task[2*i +: 2]);
        w_gnt_data = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  // Next state and the issue strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = (w_gnt_task == TASK_ILL) ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        w_issue     = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (exp_done) w_state_nxt = w_last ? ST_RESP : ST_ISSUE;
      end
      ST_RESP: begin
        if (rsp_ready) begin
`ifdef PAILLIER_RNG_REFRESH_EN
          w_state_nxt = (r_task == TASK_ENC) ? ST_REFRESH_ISSUE : ST_IDLE;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
      ST_REFRESH_ISSUE: begin
        w_issue     = 1'b1;
        w_state_nxt = ST_REFRESH_WAIT;
      end
      ST_REFRESH_WAIT: begin
        if (exp_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Engine op and operands for the step about to be issued. The default is
  // the rng step, which also serves the post-encrypt refresh.
  always_comb begin
    w_op   = OP_MODEXP_N2;
    w_base = r_random;
    w_expo = N;
    if (r_state == ST_ISSUE) begin
      case (r_task)
        TASK_ENC: begin
          if (r_step == 2'd0) begin
            w_op = OP_MODEXP_N2; w_base = N_PLUS_1_MONT; w_expo = r_data;
          end else begin
            w_op = OP_MODMUL_N2; w_base = r_prev;        w_expo = r_random;
          end
        end
        TASK_DEC: begin
          if (r_step == 2'd0) begin
            w_op = OP_MODEXP_N2; w_base = r_data;        w_expo = LAMBDA;
          end else if (r_step == 2'd1) begin
            // L(x) = (x - 1) / N; the division is folded into N_INV_R_MONT.
            w_op = OP_MODMUL_N2; w_base = r_prev - DATA_W'(1); w_expo = N_INV_R_MONT;
          end else begin
            w_op = OP_MODMUL_N;  w_base = r_prev;        w_expo = MU_MONT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live         <= 1'b0;
      r_task         <= TASK_ENC;
      r_step         <= 2'd0;
      r_data         <= '0;
      r_prev         <= '0;
      r_random       <= RANDOM_SEED;
      r_exp_start    <= 1'b0;
      r_exp_task     <= OP_MODEXP_N2;
      r_exp_base     <= '0;
      r_exp_exponent <= '0;
      r_rsp_ch       <= '0;
      r_rsp_data     <= '0;
      r_rsp_err      <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      r_live      <= 1'b1;
      // exp_start is registered so operands and strobe leave together,
      // two cycles after the request handshake.
      r_exp_start <= w_issue;
      if (w_issue) begin
        r_exp_task     <= w_op;
        r_exp_base     <= w_base;
        r_exp_exponent <= w_expo;
      end
      if (exp_done && (r_state != ST_WAIT) && (r_state != ST_REFRESH_WAIT))
        r_err_spurious <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_task   <= w_gnt_task;
            r_data   <= w_gnt_data;
            r_step   <= 2'd0;
            r_rsp_ch <= w_gnt_idx;
            if (w_gnt_task == TASK_ILL) begin
              r_rsp_data <= '0;
              r_rsp_err  <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (exp_done) begin
            r_prev <= exp_power;
            if (w_last) begin
              r_rsp_data <= exp_power;
              r_rsp_err  <= 1'b0;
              if (r_task == TASK_RNG) r_random <= exp_power;
            end else begin
              r_step <= r_step + 2'd1;
            end
          end
        end
        ST_REFRESH_WAIT: begin
          if (exp_done) r_random <= exp_power;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid    = (r_state == ST_RESP);
  assign rsp_ch       = r_rsp_ch;
  assign rsp_data     = r_rsp_data;
  assign rsp_err      = r_rsp_err;
  assign exp_start    = r_exp_start;
  assign exp_task     = r_exp_task;
  assign exp_base     = r_exp_base;
  assign exp_exponent = r_exp_exponent;
  assign busy         = (r_state != ST_IDLE);
  assign err_spurious = r_err_spurious;

endmodule

// File: tb/tb_paillier_sequencer.sv
// -----------------------------------------------------------------------------
// tb_paillier_sequencer
// Directed bench for paillier_sequencer with a 32-bit datapath and four
// channels. The bench plays the modexp engine: it waits for exp_start,
// captures the op and operands, then returns a chosen result one cycle later.
// -----------------------------------------------------------------------------
module tb_paillier_sequencer;

  localparam int          NCH    = 4;
  localparam int          DW     = 32;
  localparam logic [31:0] P_N    = 32'h0000_00C5;
  localparam logic [31:0] P_NP1  = 32'h0000_00C6;
  localparam logic [31:0] P_LAM  = 32'h0000_0031;
  localparam logic [31:0] P_NINV = 32'h0000_0044;
  localparam logic [31:0] P_MU   = 32'h0000_0055;
  localparam logic [31:0] P_SEED = 32'h1234_5678;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_ready;
  logic [2*NCH-1:0]  req_task;
  logic [DW*NCH-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_ch;
  logic [DW-1:0]     rsp_data;
  logic              rsp_err;
  logic              exp_start;
  logic [1:0]        exp_task;
  logic [DW-1:0]     exp_base;
  logic [DW-1:0]     exp_exponent;
  logic              exp_done;
  logic [DW-1:0]     exp_power;
  logic              busy;
  logic              err_spurious;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_random;

  paillier_sequencer #(
    .NUM_CH(NCH), .DATA_W(DW), .N(P_N), .N_PLUS_1_MONT(P_NP1), .LAMBDA(P_LAM),
    .N_INV_R_MONT(P_NINV), .MU_MONT(P_MU), .RANDOM_SEED(P_SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_task(req_task), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_ch(rsp_ch), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .exp_start(exp_start), .exp_task(exp_task), .exp_base(exp_base),
    .exp_exponent(exp_exponent), .exp_done(exp_done), .exp_power(exp_power),
    .busy(busy), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; exp_done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_random = P_SEED;
  endtask

  task automatic drive_req(input int ch, input logic [1:0] tsk, input logic [31:0] d);
    req_valid             = '0;
    req_valid[ch]         = 1'b1;
    req_task[2*ch +: 2]   = tsk;
    req_data[32*ch +: 32] = d;
  endtask

  // Engine stand-in: bounded wait for exp_start, capture, answer a cycle later.
  task automatic run_step(input logic [31:0] result, output logic [1:0] op,
                          output logic [31:0] base, output logic [31:0] expo,
                          output int lat, output bit one_cycle);
    lat = 0; op = '0; base = '0; expo = '0; one_cycle = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (exp_start === 1'b1) begin lat = i; break; end
    end
    if (lat == 0) begin
      checks++; failures++;
      $display("FAIL exp_start_timeout: exp_start=0 for 20 cycles, required 1");
    end else begin
      op = exp_task; base = exp_base; expo = exp_exponent;
      @(negedge clk);
      one_cycle = (exp_start === 1'b0);
      exp_done = 1'b1; exp_power = result;
      @(negedge clk);
      exp_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; req_task = '0; req_data = '0;
    rsp_ready = 1'b1; exp_done = 1'b0; exp_power = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_ch, rsp_data, rsp_err, exp_start, exp_task, exp_base,
         exp_exponent, busy, err_spurious} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b rv=%b ch=%0d d=%h err=%b st=%b busy=%b sp=%b, required all 0",
               req_ready, rsp_valid, rsp_ch, rsp_data, rsp_err, exp_start, busy, err_spurious);
    end
    req_valid = '0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_random = P_SEED;
    checks++;
    if ({busy, rsp_valid, exp_start} !== 3'b000) begin
      failures++; $display("FAIL reset_idle: busy/rv/start=%b required 000", {busy, rsp_valid, exp_start});
    end
  endtask

  task automatic test_encrypt(input int ch, input logic [31:0] m, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] rr);
    logic [1:0] op; logic [31:0] b, e; int lat; bit one; logic [3:0] want_rdy;
    want_rdy = 4'(1 << ch);
    drive_req(ch, 2'b00, m);
    #1;
    checks++;
    if (req_ready !== want_rdy) begin
      failures++; $display("FAIL enc_ready: got %b required %b", req_ready, want_rdy);
    end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if ({req_ready, exp_start, busy} !== 6'b000001) begin
      failures++; $display("FAIL enc_issue_cycle: ready=%b start=%b busy=%b required 0000,0,1",
                           req_ready, exp_start, busy);
    end
    run_step(r1, op, b, e, lat, one);
    checks++;
    if (lat != 1 || !one) begin
      failures++; $display("FAIL enc_latency: start %0d cycles after ready-cycle+1 (1 required), single=%b", lat, one);
    end
    checks++;
    if ({op, b, e} !== {2'b00, P_NP1, m}) begin
      failures++; $display("FAIL enc_step0: got op=%b base=%h exp=%h required 00 %h %h", op, b, e, P_NP1, m);
    end
    run_step(r2, op, b, e, lat, one);
    checks++;
    if ({op, b, e} !== {2'b01, r1, exp_random}) begin
      failures++; $display("FAIL enc_step1: got op=%b base=%h exp=%h required 01 %h %h", op, b, e, r1, exp_random);
    end
    checks++;
    if ({rsp_valid, rsp_ch, rsp_data, rsp_err} !== {1'b1, 2'(ch), r2, 1'b0}) begin
      failures++; $display("FAIL enc_rsp: got v=%b ch=%0d d=%h err=%b required 1 %0d %h 0",
                           rsp_valid, rsp_ch, rsp_data, rsp_err, ch, r2);
    end
`ifdef PAILLIER_RNG_REFRESH_EN
    run_step(rr, op, b, e, lat, one);
    checks++;
    if ({op, b, e} !== {2'b00, exp_random, P_N}) begin
      failures++; $display("FAIL enc_refresh: got op=%b base=%h exp=%h required 00 %h %h", op, b, e, exp_random, P_N);
    end
    exp_random = rr;
`else
    @(negedge clk);
    if (rr == 32'hFFFF_FFFF) $display("note: refresh value unused in this build");
`endif
    checks++;
    if ({busy, rsp_valid} !== 2'b00) begin
      failures++; $display("FAIL enc_done_idle: busy=%b rv=%b required 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_decrypt(input int ch, input logic [31:0] c, input logic [31:0] r0,
                              input logic [31:0] r1, input logic [31:0] r2);
    logic [1:0] op; logic [31:0] b, e, dec_base; int lat; bit one;
    dec_base = r0 - 32'd1;
    drive_req(ch, 2'b01, c);
    @(negedge clk);
    req_valid = '0;
    run_step(r0, op, b, e, lat, one);
    checks++;
    if ({op, b, e} !== {2'b00, c, P_LAM}) begin
      failures++; $display("FAIL dec_step0: got op=%b base=%h exp=%h required 00 %h %h", op, b, e, c, P_LAM);
    end
    run_step(r1, op, b, e, lat, one);
    checks++;
    if ({op, b, e} !== {2'b01, dec_base, P_NINV}) begin
      failures++; $display("FAIL dec_step1: got op=%b base=%h exp=%h required 01 %h %h", op, b, e, dec_base, P_NINV);
    end
    run_step(r2, op, b, e, lat, one);
    checks++;
    if ({op, b, e} !== {2'b11, r1, P_MU}) begin
      failures++; $display("FAIL dec_step2: got op=%b base=%h exp=%h required 11 %h %h", op, b, e, r1, P_MU);
    end
    checks++;
    if ({rsp_valid, rsp_ch, rsp_data, rsp_err} !== {1'b1, 2'(ch), r2, 1'b0}) begin
      failures++; $display("FAIL dec_rsp: got v=%b ch=%0d d=%h err=%b required 1 %0d %h 0",
                           rsp_valid, rsp_ch, rsp_data, rsp_err, ch, r2);
    end
    @(negedge clk);
  endtask

  task automatic test_rng(input int ch, input logic [31:0] r);
    logic [1:0] op; logic [31:0] b, e; int lat; bit one;
    drive_req(ch, 2'b10, 32'h0);
    @(negedge clk);
    req_valid = '0;
    run_step(r, op, b, e, lat, one);
    checks++;
    if ({op, b, e} !== {2'b00, exp_random, P_N}) begin
      failures++; $display("FAIL rng_step: got op=%b base=%h exp=%h required 00 %h %h", op, b, e, exp_random, P_N);
    end
    checks++;
    if ({rsp_valid, rsp_ch, rsp_data, rsp_err} !== {1'b1, 2'(ch), r, 1'b0}) begin
      failures++; $display("FAIL rng_rsp: got v=%b ch=%0d d=%h err=%b required 1 %0d %h 0",
                           rsp_valid, rsp_ch, rsp_data, rsp_err, ch, r);
    end
    exp_random = r;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    bit seen_start = 1'b0; int rsp_at = 0;
    drive_req(2, 2'b11, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++; $display("FAIL ill_ready: got %b required 0100", req_ready);
    end
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      req_valid = '0;
      if (exp_start === 1'b1) seen_start = 1'b1;
      if (rsp_valid === 1'b1) begin rsp_at = i; break; end
    end
    checks++;
    if (rsp_at == 0 || seen_start) begin
      failures++; $display("FAIL ill_timing: rsp cycle=%0d start_seen=%b required 1..2 and 0", rsp_at, seen_start);
    end
    checks++;
    if ({rsp_ch, rsp_data, rsp_err} !== {2'd2, 32'h0, 1'b1}) begin
      failures++; $display("FAIL ill_rsp: got ch=%0d d=%h err=%b required 2 0 1", rsp_ch, rsp_data, rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    drive_req(2, 2'b11, 32'h0);
    @(negedge clk);
    req_valid = 4'b1011;
    req_task  = '1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rsp_valid, rsp_ch, rsp_data, rsp_err, req_ready, busy} !==
          {1'b1, 2'd2, 32'h0, 1'b1, 4'b0000, 1'b1}) begin
        failures++; $display("FAIL bp_hold[%0d]: v=%b ch=%0d d=%h err=%b ready=%b busy=%b required 1 2 0 1 0000 1",
                             i, rsp_valid, rsp_ch, rsp_data, rsp_err, req_ready, busy);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if ({busy, rsp_valid} !== 2'b00) begin
      failures++; $display("FAIL bp_release: busy=%b rv=%b required 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    int got_start = 0; bit quiet = 1'b1;
    drive_req(1, 2'b00, 32'h3);
    @(negedge clk);
    req_valid = '0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (exp_start === 1'b1) begin got_start = i; break; end
    end
    checks++;
    if (got_start == 0) begin
      failures++; $display("FAIL rmid_start: exp_start=0 for 5 cycles, required 1");
    end
    rst_n = 1'b0; exp_done = 1'b1; exp_power = 32'h99;
    #1;
    checks++;
    if ({req_ready, rsp_valid, exp_start, exp_base, exp_exponent, busy, err_spurious} !== '0) begin
      failures++; $display("FAIL rmid_reset_out: start=%b base=%h busy=%b sp=%b required all 0",
                           exp_start, exp_base, busy, err_spurious);
    end
    @(negedge clk);
    exp_done = 1'b0; rst_n = 1'b1;
    exp_random = P_SEED;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({rsp_valid, exp_start, busy, err_spurious} !== 4'b0000) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      failures++; $display("FAIL rmid_quiet: rv/start/busy/sp=%b after abort, required 0000",
                           {rsp_valid, exp_start, busy, err_spurious});
    end
    test_rng(3, 32'h0BAD_F00D);
  endtask

  task automatic test_round_robin();
    logic [3:0] seen[5]; logic [3:0] want[5]; int n = 0;
    want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100; want[3] = 4'b1000; want[4] = 4'b0001;
    do_reset();
    rsp_ready = 1'b1; req_task = '1; req_valid = '1;
    for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
      #1;
      if (req_ready !== 4'b0000) begin seen[n] = req_ready; n++; end
      @(negedge clk);
    end
    req_valid = '0;
    checks++;
    if (n != 5) begin
      failures++; $display("FAIL rr_count: saw %0d grants in 40 cycles, required 5", n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (seen[k] !== want[k]) begin
        failures++; $display("FAIL rr_grant[%0d]: got %b required %b", k, seen[k], want[k]);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_spurious();
    exp_done = 1'b1; exp_power = 32'h1;
    @(negedge clk);
    exp_done = 1'b0;
    checks++;
    if ({err_spurious, busy} !== 2'b10) begin
      failures++; $display("FAIL spur_set: sp=%b busy=%b required 1 0", err_spurious, busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (err_spurious !== 1'b1) begin
      failures++; $display("FAIL spur_sticky: got %b required 1", err_spurious);
    end
    do_reset();
    checks++;
    if (err_spurious !== 1'b0) begin
      failures++; $display("FAIL spur_clear: got %b required 0", err_spurious);
    end
  endtask

  initial begin
    test_reset();
    test_encrypt(1, 32'h5, 32'h11, 32'h22, 32'h3C3C);
    test_decrypt(0, 32'h7, 32'h10, 32'h20, 32'h30);
    test_decrypt(2, 32'h1, 32'h0, 32'h5, 32'h6);
    test_rng(3, 32'h77);
    test_encrypt(1, 32'h9, 32'h44, 32'h55, 32'h66);
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_round_robin();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/paillier_sequencer.md
PAILLIER_SEQUENCER -- requirements
Module: paillier_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4: number of requester channels, 1..8.
REQ-002 Parameter DATA_W, default 528: operand/result width in bits.
REQ-003 Parameters N, N_PLUS_1_MONT, LAMBDA, N_INV_R_MONT, MU_MONT, RANDOM_SEED, each DATA_W bits, default 0: key constants in Montgomery form.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  in  NUM_CH  per-channel request valid.
REQ-007 req_ready  out  NUM_CH  per-channel accept; one-hot or zero.
REQ-008 req_task  in  2*NUM_CH  per-channel task: 00 encrypt, 01 decrypt, 10 rng, 11 illegal.
REQ-009 req_data  in  DATA_W*NUM_CH  per-channel operand; channel i occupies slice i.
REQ-010 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-011 rsp_ch  out  clog2(NUM_CH), min 1  originating channel.
REQ-012 rsp_data / rsp_err  out  DATA_W / 1  result; error flag.
REQ-013 exp_start / exp_task  out  1 / 2  one-cycle engine start; engine op: 00 modexp mod N^2, 01 modmul mod N^2, 10 modexp mod N, 11 modmul mod N.
REQ-014 exp_base / exp_exponent  out  DATA_W / DATA_W  engine operands, stable from exp_start until exp_done.
REQ-015 exp_done / exp_power  in  1 / DATA_W  engine one-cycle completion pulse and result.
REQ-016 busy / err_spurious  out  1 / 1  job in flight; sticky unexpected-exp_done flag.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP, REFRESH_ISSUE, REFRESH_WAIT.
REQ-018 IDLE: round-robin grant among asserted req_valid, starting at channel after last grant; req_ready high for granted channel only, one cycle; task, data, channel latched; next state ISSUE.
REQ-019 Illegal task 11: no engine op; go to RESP with rsp_err=1, rsp_data=0.
REQ-020 ISSUE: exp_start=1 for exactly one cycle; next state WAIT.
REQ-021 Encrypt: step0 modexp(N_PLUS_1_MONT, m); step1 modmul(prev, random).
REQ-022 Decrypt: step0 modexp(c, LAMBDA); step1 modmul(prev-1, N_INV_R_MONT); step2 modmul mod N(prev, MU_MONT).
REQ-023 Rng: step0 modexp(random, N); result written to random register and returned.
REQ-024 prev is exp_power of the previous step, registered on exp_done; prev-1 wraps modulo 2^DATA_W.
REQ-025 WAIT: on exp_done, if more steps, step counter increments and state returns to ISSUE; else rsp_data<=exp_power, next state RESP.
REQ-026 Latency: exp_start two cycles after req_ready; rsp_valid one cycle after final exp_done.
REQ-027 RESP: rsp_valid, rsp_ch, rsp_data, rsp_err held stable until rsp_ready; on rsp_valid&rsp_ready go to IDLE (or REFRESH_ISSUE per REQ-034).
REQ-028 No new grant while busy; busy=1 in every state except IDLE.
REQ-029 exp_done in any state other than WAIT/REFRESH_WAIT is ignored and sets err_spurious; err_spurious clears only on reset.
REQ-030 exp_done coincident with rst_n low is discarded.

Reset
REQ-031 rst_n low: state IDLE, all outputs 0, random=RANDOM_SEED, round-robin pointer at channel 0, step counter 0, err_spurious 0.
REQ-032 Reset mid-job aborts it; no response is issued for the aborted job; exp_start stays 0 until a new grant.

Configuration
REQ-033 Macro PAILLIER_RNG_REFRESH_EN selects automatic randomness refresh.
REQ-034 Defined: after an encrypt response handshake, REFRESH_ISSUE/REFRESH_WAIT run one rng step (REQ-023) with no response, then IDLE; busy stays 1. Undefined: random changes only via explicit rng task; REFRESH states unreachable.

Structure
REQ-035 Shared package paillier_pkg: task codes, engine op codes, FSM state encoding, step-count constants.
REQ-036 Sub-module rr_arbiter (NUM_CH request vector, grant one-hot, pointer update on accept).
REQ-037 The modexp engine is external and not instantiated in this block.

Verification
REQ-038 Encrypt ch1 m=5, engine model returning 0x11 then 0x22 -> exp_start pulses carry (00,N_PLUS_1_MONT,5), (01,0x11,random); rsp_ch=1, rsp_data=0x22, rsp_err=0.
REQ-039 Decrypt ch0 c=7, model returns 0x10, 0x20, 0x30 -> step1 base 0x0F, step2 exp_task=11, exponent MU_MONT; rsp_data=0x30.
REQ-040 req_valid=4'b1111 continuously with rsp_ready=1 -> grants in order 0,1,2,3,0.
REQ-041 req_task=11 on ch2 -> no exp_start; rsp_err=1, rsp_data=0, rsp_ch=2 within 2 cycles.
REQ-042 rsp_ready low 10 cycles -> rsp outputs stable, no new req_ready; reset during WAIT -> rsp_valid never asserts, random=RANDOM_SEED.
REQ-043 Spurious exp_done in IDLE -> err_spurious=1; with PAILLIER_RNG_REFRESH_EN, encrypt then one extra exp_start (task 00, exponent N) updates random.
